bcd_to_binary: RTL and testbench

Sequential 3-digit BCD to 8-bit binary converter using reverse double-dabble: shift right, then correct. It is the inverse of the combinational binary-to-BCD path. It converts keypad/7-segment-entry operands (000–999) back into binary for the 4-bit ALU datapath on the FPGA board. It takes one conversion request at a time through a start/busy/valid handshake and flags out-of-range and non-BCD inputs.

---
 rtl/bcd_to_binary.sv | 134 +++++++++++++
 tb/tb_bcd_to_binary.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble)
// Optional feature: define BCD2BIN_SAT_EN to saturate BIN to 8'hFF on overflow.
module bcd_to_binary (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [7:0] BIN,
  output logic       busy,
  output logic       valid,
  output logic       ovf,
  output logic       err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  bin_out_q, bin_out_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        err_pend_q, err_pend_d;

  logic [21:0] shifted;
  logic [11:0] bcd_fix;
  logic [9:0]  bin_sh;
  logic        digit_bad;
  logic        ovf_res;
  logic [7:0]  bin_res;

  function automatic logic [3:0] fix_nib(input logic [3:0] n);
    return (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

  always_comb begin
    shifted   = {bcd_q, bin_q} >> 1;
    bin_sh    = shifted[9:0];
    bcd_fix   = {fix_nib(shifted[21:18]), fix_nib(shifted[17:14]), fix_nib(shifted[13:10])};
    digit_bad = (HUNDREDS > 4'd9) || (TENS > 4'd9) || (ONES > 4'd9);
    ovf_res   = (bin_sh[9:8] != 2'b00);
`ifdef BCD2BIN_SAT_EN
    bin_res   = ovf_res ? 8'hFF : bin_sh[7:0];
`else
    bin_res   = bin_sh[7:0];
`endif
  end

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    bin_out_d  = bin_out_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    err_d      = err_q;
    err_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (err_pend_q) begin
          valid_d   = 1'b1;
          err_d     = 1'b1;
          ovf_d     = 1'b0;
          bin_out_d = 8'h00;
        end else if (start) begin
          bcd_d = {HUNDREDS, TENS, ONES};
          bin_d = 10'd0;
          cnt_d = 4'd0;
          if (digit_bad) begin
            err_pend_d = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q + 4'd1;
        // The tenth shift leaves the exact value in bin; publish it on the same edge.
        if (cnt_q == 4'd9) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          valid_d   = 1'b1;
          ovf_d     = ovf_res;
          err_d     = 1'b0;
          bin_out_d = bin_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bcd_q      <= 12'd0;
      bin_q      <= 10'd0;
      cnt_q      <= 4'd0;
      bin_out_q  <= 8'h00;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      bin_out_q  <= bin_out_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign BIN   = bin_out_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - scoreboard bench for bcd_to_binary
// Honours BCD2BIN_SAT_EN for the expected BIN on overflow.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] HUNDREDS, TENS, ONES;
  logic [7:0] BIN;
  logic       busy, valid, ovf, err;

  bcd_to_binary dut (
    .clk(clk), .rst(rst), .start(start),
    .HUNDREDS(HUNDREDS), .TENS(TENS), .ONES(ONES),
    .BIN(BIN), .busy(busy), .valid(valid), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bin;
    logic       ovf;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic run_mon = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int h, input int t, input int o);
    exp_t e;
    int   v;
    e = '0;
    if (h > 9 || t > 9 || o > 9) begin
      e.err = 1'b1;
      return e;
    end
    v     = h * 100 + t * 10 + o;
    e.ovf = (v > 255);
`ifdef BCD2BIN_SAT_EN
    e.bin = e.ovf ? 8'hFF : 8'(v % 256);
`else
    e.bin = 8'(v % 256);
`endif
    return e;
  endfunction

  // Monitor: busy profile derived from the head request, results popped on valid.
  always @(negedge clk) begin
    if (!rst && run_mon) begin
      logic exp_busy;
      exp_t e;
      exp_busy = 1'b0;
      if (q.size() > 0)
        exp_busy = !q[0].err && (cyc >= q[0].cyc - 10) && (cyc < q[0].cyc);
      check("busy", int'(busy), int'(exp_busy));
      if (valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("BIN", int'(BIN), int'(e.bin));
          check("ovf", int'(ovf), int'(e.ovf));
          check("err", int'(err), int'(e.err));
          check("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; start stays high for 'hold' cycles with digits scrambled meanwhile.
  task automatic issue(input int h, input int t, input int o, input int hold);
    exp_t e;
    HUNDREDS = 4'(h);
    TENS     = 4'(t);
    ONES     = 4'(o);
    start    = 1'b1;
    e        = model(h, t, o);
    e.cyc    = e.err ? cyc + 2 : cyc + 11;
    q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i < hold - 1) begin
        HUNDREDS = 4'($urandom_range(0, 9));
        TENS     = 4'($urandom_range(0, 9));
        ONES     = 4'($urandom_range(0, 9));
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) return;
    end
    check("valid_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; HUNDREDS = 4'd0; TENS = 4'd0; ONES = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_BIN", int'(BIN), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    run_mon = 1'b1;
    @(negedge clk);

    issue(2, 5, 5, 1); wait_valid();
    issue(9, 9, 9, 1); wait_valid();
    issue(2, 5, 6, 1); wait_valid();
    @(negedge clk);
    issue(0, 0, 0, 1); wait_valid();
    issue(1, 2, 8, 1); wait_valid();
    repeat (2) @(negedge clk);
    issue(3, 10, 7, 1); wait_valid();
    repeat (2) @(negedge clk);
    issue(1, 0, 0, 8); wait_valid();
    repeat (3) @(negedge clk);

    issue(3, 3, 3, 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_BIN", int'(BIN), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_ovf", int'(ovf), 0);
    check("abort_err", int'(err), 0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, 4, 2, 1); wait_valid();

    for (int n = 0; n < 40; n++) begin
      int h, t, o;
      h = $urandom_range(0, 9);
      t = $urandom_range(0, 9);
      o = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: h = $urandom_range(10, 15);
          1: t = $urandom_range(10, 15);
          default: o = $urandom_range(10, 15);
        endcase
      end
      issue(h, t, o, 1);
      wait_valid();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (15) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
